// File: rtl/esp_uart_bridge_pkg.sv
// rtl/esp_uart_bridge_pkg.sv - register map constants shared by the ESP UART bridge
package esp_uart_bridge_pkg;

    // Word offsets inside the 4-word window
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_FE       = 3;
    localparam int ST_TX_DROP  = 4;
    localparam int ST_IRQ      = 5;

    // CTRL bit positions
    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_ERR_IE = 1;

    // DATA read: set when the RX FIFO had nothing to give
    localparam int DATA_EMPTY_BIT = 31;

    // The ninth TX bit only travels when byte lane 1 is enabled
    function automatic logic [8:0] tx_byte(input logic [31:0] wrdata, input logic [3:0] bytesel);
        return {bytesel[1] & wrdata[8], wrdata[7:0]};
    endfunction

endpackage

// File: rtl/esp_uart_bridge_if.sv
// rtl/esp_uart_bridge_if.sv - CPU bus slave port of the ESP UART bridge
interface esp_uart_bridge_if;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wrdata;
    logic [3:0]  bus_bytesel;
    logic        bus_wren;
    logic        bus_strobe;
    logic        bus_wait;
    logic [31:0] bus_rddata;

    modport master (
        output bus_addr, bus_wrdata, bus_bytesel, bus_wren, bus_strobe,
        input  bus_wait, bus_rddata
    );

    modport slave (
        input  bus_addr, bus_wrdata, bus_bytesel, bus_wren, bus_strobe,
        output bus_wait, bus_rddata
    );
endinterface

// File: rtl/esp_uart_bridge.sv
// rtl/esp_uart_bridge.sv - CPU register window onto the ESP UART TX/RX FIFOs
module esp_uart_bridge
    import esp_uart_bridge_pkg::*;
#(
    parameter int TX_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    esp_uart_bridge_if.slave   bus,
    output logic [8:0]         txfifo_data,
    output logic               txfifo_wr,
    input  logic               txfifo_full,
    input  logic [8:0]         rxfifo_data,
    output logic               rxfifo_rd,
    input  logic               rxfifo_empty,
    input  logic               rxfifo_overflow,
    input  logic               rx_framing_error,
    output logic               irq
);

    typedef enum logic [1:0] {IDLE, RD_ACK, TX_STALL} state_t;

    // Counter only has to reach TX_TIMEOUT-1; TX_TIMEOUT=0 disables the timeout
    localparam int CNT_W = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TX_TIMEOUT == 0) ? '0 : CNT_W'(TX_TIMEOUT - 1);

    state_t           state, state_next;
    logic [31:0]      rddata_q;
    logic [8:0]       tx_latch;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ctrl;
    logic             ovf, fe, tx_drop;

    logic             wait_c, tx_wr_c, rx_rd_c;
    logic [8:0]       tx_data_c;
    logic             rd_load, latch_load, cnt_clr, drop_set, w1c, ctrl_we;
    logic [31:0]      rd_value;
    logic [31:0]      status_val;

    logic unused_bits;
    assign unused_bits = ^{bus.bus_wrdata[31:9], bus.bus_bytesel[3:2]};

    // Live STATUS word as seen by a read in the current cycle
    always_comb begin
        status_val              = '0;
        status_val[ST_RX_AVAIL] = !rxfifo_empty;
        status_val[ST_TX_FULL]  = txfifo_full;
        status_val[ST_OVF]      = ovf;
        status_val[ST_FE]       = fe;
        status_val[ST_TX_DROP]  = tx_drop;
        status_val[ST_IRQ]      = irq;
    end

    // Access decode and FSM next-state; all bus/FIFO strobes come from here
    always_comb begin
        state_next = state;
        wait_c     = 1'b0;
        tx_wr_c    = 1'b0;
        tx_data_c  = '0;
        rx_rd_c    = 1'b0;
        rd_load    = 1'b0;
        rd_value   = '0;
        latch_load = 1'b0;
        cnt_clr    = 1'b0;
        drop_set   = 1'b0;
        w1c        = 1'b0;
        ctrl_we    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bus_strobe && !bus.bus_wren) begin
                    wait_c     = 1'b1;
                    rd_load    = 1'b1;
                    state_next = RD_ACK;
                    case (bus.bus_addr)
                        REG_STATUS: rd_value = status_val;
                        REG_DATA: begin
                            if (rxfifo_empty) begin
                                rd_value[DATA_EMPTY_BIT] = 1'b1;
                            end else begin
                                rd_value = {23'b0, rxfifo_data};
                                rx_rd_c  = 1'b1;
                            end
                        end
                        REG_CTRL: rd_value = {30'b0, ctrl};
                        default:  rd_value = '0;
                    endcase
                end else if (bus.bus_strobe) begin
                    case (bus.bus_addr)
                        REG_STATUS: w1c     = bus.bus_bytesel[0];
                        REG_CTRL:   ctrl_we = bus.bus_bytesel[0];
                        REG_DATA: begin
                            if (bus.bus_bytesel[0] && !txfifo_full) begin
                                tx_wr_c   = 1'b1;
                                tx_data_c = tx_byte(bus.bus_wrdata, bus.bus_bytesel);
                            end else if (bus.bus_bytesel[0]) begin
                                wait_c     = 1'b1;
                                latch_load = 1'b1;
                                cnt_clr    = 1'b1;
                                state_next = TX_STALL;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RD_ACK: begin
                state_next = IDLE;
            end
            TX_STALL: begin
                if (!bus.bus_strobe) begin
                    state_next = IDLE;
                end else if (!txfifo_full) begin
                    tx_wr_c    = 1'b1;
                    tx_data_c  = tx_latch;
                    state_next = IDLE;
                end else if ((TX_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    drop_set   = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_c = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational strobes are forced low while reset is held
    assign bus.bus_wait   = wait_c & ~reset;
    assign bus.bus_rddata = rddata_q;
    assign txfifo_wr      = tx_wr_c & ~reset;
    assign txfifo_data    = reset ? 9'h000 : tx_data_c;
    assign rxfifo_rd      = rx_rd_c & ~reset;

    // FSM state, read-data holding register, stalled byte and timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rddata_q <= '0;
            tx_latch <= '0;
            cnt      <= '0;
        end else begin
            state <= state_next;
            if (rd_load) begin
                rddata_q <= rd_value;
            end
            if (latch_load) begin
                tx_latch <= tx_byte(bus.bus_wrdata, bus.bus_bytesel);
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == TX_STALL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // CTRL register and sticky error flags; a new event beats a same-cycle W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= '0;
            ovf     <= 1'b0;
            fe      <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ctrl <= bus.bus_wrdata[1:0];
            end
            ovf     <= rxfifo_overflow  | (ovf     & ~(w1c & bus.bus_wrdata[ST_OVF]));
            fe      <= rx_framing_error | (fe      & ~(w1c & bus.bus_wrdata[ST_FE]));
            tx_drop <= drop_set         | (tx_drop & ~(w1c & bus.bus_wrdata[ST_TX_DROP]));
        end
    end

    // Registered level interrupt, one cycle behind its causes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[CTRL_RX_IE] & ~rxfifo_empty) |
                   (ctrl[CTRL_ERR_IE] & (ovf | fe | tx_drop));
        end
    end

endmodule

// File: tb/tb_esp_uart_bridge.sv
// tb/tb_esp_uart_bridge.sv - self-checking bench for esp_uart_bridge
module tb_esp_uart_bridge;
    import esp_uart_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  addr = '0;
    logic [31:0] wrdata = '0;
    logic [3:0]  bytesel = '0;
    logic        wren = 1'b0;
    logic        strobe = 1'b0;
    logic        txfifo_full = 1'b0;
    logic        ovf_in = 1'b0;
    logic        fe_in = 1'b0;
    logic        rx_empty = 1'b1;
    logic [8:0]  rx_data = '0;

    logic [8:0]  txd_a, txd_b;
    logic        txwr_a, txwr_b, rxrd_a, rxrd_b, irq_a, irq_b;

    esp_uart_bridge_if ia ();
    esp_uart_bridge_if ib ();

    assign ia.bus_addr = addr;    assign ib.bus_addr = addr;
    assign ia.bus_wrdata = wrdata; assign ib.bus_wrdata = wrdata;
    assign ia.bus_bytesel = bytesel; assign ib.bus_bytesel = bytesel;
    assign ia.bus_wren = wren;    assign ib.bus_wren = wren;
    assign ia.bus_strobe = strobe; assign ib.bus_strobe = strobe;

    esp_uart_bridge #(.TX_TIMEOUT(16)) dut_a (
        .clk(clk), .reset(rst), .bus(ia.slave),
        .txfifo_data(txd_a), .txfifo_wr(txwr_a), .txfifo_full(txfifo_full),
        .rxfifo_data(rx_data), .rxfifo_rd(rxrd_a), .rxfifo_empty(rx_empty),
        .rxfifo_overflow(ovf_in), .rx_framing_error(fe_in), .irq(irq_a)
    );

    esp_uart_bridge #(.TX_TIMEOUT(1023)) dut_b (
        .clk(clk), .reset(rst), .bus(ib.slave),
        .txfifo_data(txd_b), .txfifo_wr(txwr_b), .txfifo_full(txfifo_full),
        .rxfifo_data(rx_data), .rxfifo_rd(rxrd_b), .rxfifo_empty(rx_empty),
        .rxfifo_overflow(ovf_in), .rx_framing_error(fe_in), .irq(irq_b)
    );

    int total = 0;
    int bad = 0;

    logic [8:0] rxq[$];
    int         push_seq = 0;
    int         push_seen = 0;
    logic [8:0] push_val = '0;
    logic       pend = 1'b0;
    logic       take;
    int         pop_a = 0;
    int         push_a = 0;
    int         push_b = 0;
    logic [8:0] last_a = '0;

    logic       exp_ovf = 1'b0;
    logic       exp_fe = 1'b0;
    logic       exp_drop = 1'b0;
    logic [1:0] exp_ctrl = '0;

    // RX FIFO model and TX push monitor, all on the falling edge
    always @(negedge clk) begin
        take = pend;
        pend = rxrd_a;
        if (take && rxq.size() != 0) begin
            void'(rxq.pop_front());
            pop_a++;
        end
        if (push_seq != push_seen) begin
            rxq.push_back(push_val);
            push_seen = push_seq;
        end
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 9'h000 : rxq[0];
        if (txwr_a) begin
            push_a++;
            last_a = txd_a;
        end
        if (txwr_b) push_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_irq();
        return (exp_ctrl[0] && rxq.size() != 0) || (exp_ctrl[1] && (exp_ovf || exp_fe || exp_drop));
    endfunction

    function automatic logic [31:0] exp_status();
        return {26'b0, exp_irq(), exp_drop, exp_fe, exp_ovf, txfifo_full, rxq.size() != 0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                              input logic [3:0] be, output int wa, output int wb,
                              output logic [31:0] rd);
        logic done;
        done = 1'b0;
        addr = a; wrdata = d; bytesel = be; wren = w; strobe = 1'b1;
        wa = 0; wb = 0; rd = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (ib.bus_wait) wb++;
            if (!ia.bus_wait) begin
                rd = ia.bus_rddata;
                done = 1'b1;
            end else begin
                wa++;
            end
            @(posedge clk);
            #1;
        end
        strobe = 1'b0; wren = 1'b0; bytesel = '0;
        chk("bus_done", {31'b0, done}, 32'd1);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd, output int wa);
        int wb;
        bus_access(1'b0, a, 32'h0, 4'hF, wa, wb, rd);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be, output int wa);
        int wb;
        logic [31:0] rd;
        bus_access(1'b1, a, d, be, wa, wb, rd);
    endtask

    task automatic rx_push(input logic [8:0] v);
        push_val = v;
        push_seq++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          wa, wb, p0, q0, pb0, op;
        logic [31:0] d;
        logic [3:0]  be;
        logic [8:0]  v;

        #2;
        chk("reset_outs", {22'b0, ia.bus_wait, txwr_a, rxrd_a, irq_a, txd_a}, 32'h0);
        chk("reset_rddata", ia.bus_rddata, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        rd_reg(REG_STATUS, rd, wa);
        chk("status_reset", rd, 32'h0);
        chk("read_wait", wa, 1);
        rd_reg(REG_CTRL, rd, wa);
        chk("ctrl_reset", rd, 32'h0);
        wr_reg(2'd3, 32'hFFFF_FFFF, 4'hF, wa);
        chk("rsvd_wr_wait", wa, 0);
        rd_reg(2'd3, rd, wa);
        chk("rsvd_read", rd, 32'h0);

        // RX pop then empty read
        rx_push(9'h1A5);
        step();
        q0 = pop_a;
        rd_reg(REG_DATA, rd, wa);
        chk("rx_data", rd, 32'h0000_01A5);
        chk("rx_wait", wa, 1);
        chk("rx_pops", pop_a - q0, 1);
        q0 = pop_a;
        rd_reg(REG_DATA, rd, wa);
        chk("rx_empty_data", rd, 32'h8000_0000);
        chk("rx_empty_pops", pop_a - q0, 0);

        // TX pushes, ninth bit gated by bytesel[1]
        p0 = push_a;
        wr_reg(REG_DATA, 32'h0000_0141, 4'b0011, wa);
        chk("tx_wait0", wa, 0);
        chk("tx_push", push_a - p0, 1);
        chk("tx_data9", last_a, 32'h141);
        p0 = push_a;
        wr_reg(REG_DATA, 32'h0000_0141, 4'b0001, wa);
        chk("tx_data8", last_a, 32'h041);
        chk("tx_push8", push_a - p0, 1);
        p0 = push_a;
        wr_reg(REG_DATA, 32'h0000_0141, 4'b0010, wa);
        chk("tx_nopush_be0", push_a - p0, 0);

        // full for 10 cycles, then one push
        p0 = push_a; pb0 = push_b;
        txfifo_full = 1'b1;
        fork
            begin
                repeat (10) @(posedge clk);
                #1 txfifo_full = 1'b0;
            end
        join_none
        bus_access(1'b1, REG_DATA, 32'h0000_00AB, 4'b0001, wa, wb, rd);
        chk("stall_wait_a", wa, 10);
        chk("stall_wait_b", wb, 10);
        chk("stall_push_a", push_a - p0, 1);
        chk("stall_push_b", push_b - pb0, 1);
        chk("stall_data", last_a, 32'h0AB);

        // full forever: drop after 16 wait cycles on the TX_TIMEOUT=16 instance
        p0 = push_a; pb0 = push_b;
        txfifo_full = 1'b1;
        wr_reg(REG_DATA, 32'h0000_01FF, 4'b0011, wa);
        chk("timeout_wait", wa, 16);
        step();
        txfifo_full = 1'b0;
        repeat (3) step();
        chk("timeout_nopush", push_a - p0, 0);
        chk("abandon_nopush_b", push_b - pb0, 0);
        exp_drop = 1'b1;
        rd_reg(REG_STATUS, rd, wa);
        chk("status_drop", rd, exp_status());
        wr_reg(REG_STATUS, 32'h10, 4'b0001, wa);
        exp_drop = 1'b0;
        step(); step();
        rd_reg(REG_STATUS, rd, wa);
        chk("status_drop_clr", rd, exp_status());

        // error interrupt on overflow
        wr_reg(REG_CTRL, 32'h2, 4'b0001, wa);
        exp_ctrl = 2'h2;
        rd_reg(REG_CTRL, rd, wa);
        chk("ctrl_rb", rd, 32'h2);
        ovf_in = 1'b1;
        @(negedge clk);
        chk("irq_ovf_t0", irq_a, 0);
        step();
        ovf_in = 1'b0;
        exp_ovf = 1'b1;
        @(negedge clk);
        chk("irq_ovf_t1", irq_a, 0);
        @(negedge clk);
        chk("irq_ovf_t2", irq_a, 1);
        step();
        rd_reg(REG_STATUS, rd, wa);
        chk("status_ovf", rd, exp_status());
        wr_reg(REG_STATUS, 32'h04, 4'b0001, wa);
        exp_ovf = 1'b0;
        step();
        @(negedge clk);
        chk("irq_ovf_clr", irq_a, 0);
        step();
        rd_reg(REG_STATUS, rd, wa);
        chk("status_ovf_clr", rd, exp_status());

        // overflow coincident with W1C: set wins
        ovf_in = 1'b1;
        wr_reg(REG_STATUS, 32'h04, 4'b0001, wa);
        ovf_in = 1'b0;
        exp_ovf = 1'b1;
        step(); step();
        rd_reg(REG_STATUS, rd, wa);
        chk("status_set_wins", rd, exp_status());

        // framing error, then clear both
        fe_in = 1'b1;
        step();
        fe_in = 1'b0;
        exp_fe = 1'b1;
        step(); step();
        rd_reg(REG_STATUS, rd, wa);
        chk("status_fe", rd, exp_status());
        wr_reg(REG_STATUS, 32'h0C, 4'b0001, wa);
        exp_ovf = 1'b0; exp_fe = 1'b0;
        step(); step();
        rd_reg(REG_STATUS, rd, wa);
        chk("status_all_clr", rd, exp_status());
        chk("irq_all_clr", irq_a, 0);

        // RX interrupt follows FIFO occupancy
        wr_reg(REG_CTRL, 32'h1, 4'b0001, wa);
        exp_ctrl = 2'h1;
        step();
        rx_push(9'h055);
        @(negedge clk);
        chk("irq_rx_t0", irq_a, 0);
        step();
        @(negedge clk);
        chk("irq_rx_t1", irq_a, 1);
        step();
        rd_reg(REG_DATA, rd, wa);
        chk("irq_rx_data", rd, 32'h055);
        @(negedge clk);
        chk("irq_rx_fall", irq_a, 0);
        step();

        // randomized mix against the FIFO/register model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                if (rxq.size() < 4) rx_push(9'($urandom));
                step();
            end else if (op == 1) begin
                q0 = pop_a;
                d  = (rxq.size() == 0) ? 32'h8000_0000 : {23'b0, rxq[0]};
                p0 = (rxq.size() == 0) ? 0 : 1;
                rd_reg(REG_DATA, rd, wa);
                chk("rnd_rx_data", rd, d);
                chk("rnd_rx_pops", pop_a - q0, p0);
                chk("rnd_rx_wait", wa, 1);
            end else begin
                d  = $urandom;
                be = 4'($urandom_range(0, 15));
                v  = {(be[1] ? d[8] : 1'b0), d[7:0]};
                p0 = push_a;
                wr_reg(REG_DATA, d, be, wa);
                chk("rnd_tx_wait", wa, 0);
                chk("rnd_tx_push", push_a - p0, be[0] ? 1 : 0);
                if (be[0]) chk("rnd_tx_data", last_a, {23'b0, v});
            end
        end
        rd_reg(REG_STATUS, rd, wa);
        chk("rnd_status", rd, exp_status());

        // reset while stalled
        p0 = push_a;
        txfifo_full = 1'b1;
        addr = REG_DATA; wrdata = 32'h1AA; bytesel = 4'b0001; wren = 1'b1; strobe = 1'b1;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", {22'b0, ia.bus_wait, txwr_a, rxrd_a, irq_a, txd_a}, 32'h0);
        chk("rst_mid_rddata", ia.bus_rddata, 32'h0);
        strobe = 1'b0; wren = 1'b0; bytesel = '0;
        step();
        rst = 1'b0;
        exp_ctrl = '0;
        step();
        txfifo_full = 1'b0;
        repeat (5) step();
        chk("rst_mid_nopush", push_a - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/esp_uart_bridge.md
Name: esp_uart_bridge

Overview:
CPU bus slave that exposes the aqp_esp_uart TX/RX FIFOs to the aq32 CPU as a 4-word register window. It sits between the CPU bus interconnect (one strobe decode, e.g. 0xFF40_0000) and aqp_esp_uart, replacing the tied-off esp_tx_wr and esp_rx_rd. It provides wait-state handshaking, sticky error flags, a TX-full stall with timeout, and a level interrupt for one cpu_irq bit.

Parameters:
TX_TIMEOUT, 1023, max cycles a DATA write stalls on txfifo_full before the byte is dropped; 0 = stall forever

Ports:
clk  in  1  system clock (28.63636 MHz)
reset  in  1  asynchronous, active-high reset
bus_addr  in  2  word offset, cpu_addr[3:2]
bus_wrdata  in  32  write data
bus_bytesel  in  4  byte enables
bus_wren  in  1  1 = write, 0 = read
bus_strobe  in  1  access request, already address-decoded
bus_wait  out  1  stall; the access completes on strobe && !wait
bus_rddata  out  32  read data, valid when strobe && !wait && !wren
txfifo_data  out  9  byte to UART TX FIFO
txfifo_wr  out  1  one-cycle push
txfifo_full  in  1  TX FIFO full
rxfifo_data  in  9  RX FIFO head (show-ahead)
rxfifo_rd  out  1  one-cycle pop
rxfifo_empty  in  1  RX FIFO empty
rxfifo_overflow  in  1  overflow indication (pulse or level)
rx_framing_error  in  1  framing error indication (pulse or level)
irq  out  1  level interrupt request, registered

Behaviour:
- Reset values: bus_wait=0, bus_rddata=0, txfifo_wr=0, rxfifo_rd=0, txfifo_data=0, irq=0. CTRL=0, all sticky flags=0, FSM=IDLE, timeout counter=0.
- Register map:
  - 0 STATUS R: b0 rx_avail=!rxfifo_empty, b1 tx_full, b2 ovf, b3 fe, b4 tx_drop, b5 irq. W1C on b2..b4; bytesel[0] required.
  - 1 DATA R: {bit31=empty, 22'b0, 9-bit data}. W: push.
  - 2 CTRL RW: b0 rx_ie, b1 err_ie; bytesel[0] required.
  - 3 reserved: reads 0, writes ignored.
- FSM states: IDLE, RD_ACK, TX_STALL.
- IDLE, read:
  - bus_wait=1 in the first cycle.
  - bus_rddata is registered from the selected source; next state is RD_ACK.
  - DATA read with !rxfifo_empty: rxfifo_rd pulses exactly once, in this same cycle; the data is captured from rxfifo_data.
  - DATA read with rxfifo_empty: returns 0x8000_0000 and does not pop.
- RD_ACK: bus_wait=0, bus_rddata held, then return to IDLE. Read latency is 1 wait cycle, so the access completes in cycle 2.
- IDLE, write:
  - Register writes complete with zero wait states, in the strobe cycle.
  - DATA write with bytesel[0]=0: completes with no push.
  - DATA write with bytesel[0]=1 and !txfifo_full: txfifo_wr=1 in the same cycle. txfifo_data = {bytesel[1] ? wrdata[8] : 0, wrdata[7:0]}. bus_wait=0.
  - DATA write with bytesel[0]=1 and txfifo_full: bus_wait=1, data latched, next state is TX_STALL, counter cleared.
- TX_STALL:
  - bus_wait=1 while stalled; counter increments each cycle.
  - When txfifo_full drops: push the latched byte that cycle, bus_wait=0, go to IDLE.
  - When counter reaches TX_TIMEOUT-1 while still full (TX_TIMEOUT≠0): no push, set tx_drop, bus_wait=0, go to IDLE.
  - If full drops in the same cycle as the timeout, the push wins and tx_drop is not set.
- Sticky flags:
  - ovf and fe set on any cycle their input is high; tx_drop set on timeout.
  - Cleared only by W1C.
  - Set wins over a simultaneous clear.
- irq, registered: (rx_ie && !rxfifo_empty) || (err_ie && (ovf||fe||tx_drop)). It updates one cycle after its causes.
- Back-to-back accesses: a new access may begin in the cycle after completion. An access never produces more than one push or one pop.
- Reset mid-operation (TX_STALL or RD_ACK): immediate return to IDLE. No push or pop is issued, and the latched byte is discarded.
- Strobe deasserted in TX_STALL: not legal for the CPU. The RTL still returns to IDLE without pushing.

Decomposition:
- Shared header/package esp_uart_regs: register offsets (STATUS=0, DATA=1, CTRL=2), STATUS/CTRL bit positions, DATA_EMPTY_BIT=31.
- FSM state encodings stay local to the block.
- No sub-module; a single flat module of about 200 lines.

Test Plan:
- RX byte 0x1A5 in FIFO, CPU reads DATA -> wait=1 for 1 cycle, rddata=0x0000_01A5, rxfifo_rd pulses exactly 1 cycle. A second read with FIFO empty -> 0x8000_0000 and no pop.
- Write DATA 0x0000_0141, bytesel=0011, not full -> txfifo_wr for 1 cycle, txfifo_data=0x141, zero wait. The same write with bytesel=0001 -> txfifo_data=0x041.
- txfifo_full held 10 cycles during a DATA write, TX_TIMEOUT=1023 -> wait for 10 cycles, then one push of the latched byte. Full held forever with TX_TIMEOUT=16 -> completes after 16 cycles, no push, STATUS b4=1.
- Pulse rxfifo_overflow 1 cycle with CTRL=0x2 -> STATUS b2=1, irq=1 on the following cycle. W1C 0x04 -> b2=0, irq=0. Overflow pulse coincident with the W1C -> b2 stays 1.
- CTRL=0x1, RX FIFO goes non-empty -> irq rises 1 cycle later. Popping the last byte -> irq falls 1 cycle after rxfifo_empty rises.
- Assert reset during TX_STALL -> all outputs 0 immediately. Deassert reset, then full drops -> no txfifo_wr ever issued.
